// File: rtl/msu_sd_pkg.sv
// ------------------------------------------------------------------
// msu_sd_pkg: shared types and defaults for the MSU SD arbiter.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package msu_sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  localparam logic OWN_AUD = 1'b0;
  localparam logic OWN_DAT = 1'b1;

  localparam int DEF_SECTOR_WORDS   = 256;
  localparam int DEF_TIMEOUT        = 4096;
  localparam int DEF_AUD_STREAK_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/msu_sd_req_slot.sv
// ------------------------------------------------------------------
// msu_sd_req_slot: one-deep request holder; drops requests while full.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module msu_sd_req_slot (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] lba_i,
  input  logic        grant_i,
  output logic        pending_o,
  output logic [31:0] lba_o
);

  logic        pending_q, pending_d;
  logic [31:0] lba_q, lba_d;

  always_comb begin
    pending_d = pending_q;
    lba_d     = lba_q;
    if (grant_i) begin
      pending_d = 1'b0;
    end else if (req_i && !pending_q) begin
      pending_d = 1'b1;
      lba_d     = lba_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      lba_q     <= 32'd0;
    end else begin
      pending_q <= pending_d;
      lba_q     <= lba_d;
    end
  end

  assign pending_o = pending_q;
  assign lba_o     = lba_q;

endmodule

`default_nettype wire

// File: rtl/msu_sd_arbiter.sv
// ------------------------------------------------------------------
// msu_sd_arbiter: shares the SD sector-read port between MSU audio and data.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module msu_sd_arbiter
  import msu_sd_pkg::*;
#(
  parameter int SECTOR_WORDS   = DEF_SECTOR_WORDS,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int AUD_STREAK_MAX = DEF_AUD_STREAK_MAX
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        aud_req_i,
  input  logic [31:0] aud_lba_i,
  output logic        aud_busy_o,
  output logic        aud_buff_wr_o,
  output logic        aud_done_o,
  output logic        aud_err_o,
  input  logic        dat_req_i,
  input  logic [31:0] dat_lba_i,
  output logic        dat_busy_o,
  output logic        dat_buff_wr_o,
  output logic        dat_done_o,
  output logic        dat_err_o,
  output logic [31:0] sd_lba_o,
  output logic        sd_rd_o,
  input  logic        sd_ack_i,
  input  logic        sd_buff_wr_i
);

  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SKW = (AUD_STREAK_MAX > 0) ? $clog2(AUD_STREAK_MAX + 1) : 1;
  localparam logic [TW-1:0]  TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SKW-1:0] STREAK_CAP = SKW'(AUD_STREAK_MAX);
  localparam logic [8:0]     WORDS      = 9'(SECTOR_WORDS);

  logic        aud_pend, dat_pend;
  logic [31:0] aud_lba, dat_lba;
  logic        grant_aud, grant_dat;

  msu_sd_req_slot u_aud_slot (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (aud_req_i),
    .lba_i     (aud_lba_i),
    .grant_i   (grant_aud),
    .pending_o (aud_pend),
    .lba_o     (aud_lba)
  );

  msu_sd_req_slot u_dat_slot (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (dat_req_i),
    .lba_i     (dat_lba_i),
    .grant_i   (grant_dat),
    .pending_o (dat_pend),
    .lba_o     (dat_lba)
  );

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rd_q, rd_d;
  logic [31:0]    lba_q, lba_d;
  logic [SKW-1:0] streak_q, streak_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [8:0]     wcnt_q, wcnt_d;
  logic           aud_done_q, aud_done_d, aud_err_q, aud_err_d;
  logic           dat_done_q, dat_done_d, dat_err_q, dat_err_d;
  logic           dat_wins;

  // Audio wins unless data has waited out a full audio streak.
  assign dat_wins = dat_pend && (!aud_pend || (streak_q == STREAK_CAP));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rd_d       = rd_q;
    lba_d      = lba_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    wcnt_d     = wcnt_q;
    aud_done_d = 1'b0;
    aud_err_d  = 1'b0;
    dat_done_d = 1'b0;
    dat_err_d  = 1'b0;
    grant_aud  = 1'b0;
    grant_dat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (aud_pend || dat_pend) begin
          state_d = ISSUE;
          rd_d    = 1'b1;
          tmo_d   = '0;
          if (dat_wins) begin
            owner_d   = OWN_DAT;
            lba_d     = dat_lba;
            grant_dat = 1'b1;
            streak_d  = '0;
          end else begin
            owner_d   = OWN_AUD;
            lba_d     = aud_lba;
            grant_aud = 1'b1;
            if (streak_q != STREAK_CAP) streak_d = streak_q + SKW'(1);
          end
        end
      end
      ISSUE: begin
        if (sd_ack_i) begin
          rd_d    = 1'b0;
          wcnt_d  = '0;
          state_d = XFER;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          rd_d    = 1'b0;
          state_d = IDLE;
          if (owner_q == OWN_AUD) aud_err_d = 1'b1;
          else                    dat_err_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      XFER: begin
        if (sd_ack_i) begin
          if (sd_buff_wr_i && (wcnt_q != 9'd511)) wcnt_d = wcnt_q + 9'd1;
        end else begin
          state_d = IDLE;
          if (owner_q == OWN_AUD) begin
            aud_done_d = (wcnt_q == WORDS);
            aud_err_d  = (wcnt_q != WORDS);
          end else begin
            dat_done_d = (wcnt_q == WORDS);
            dat_err_d  = (wcnt_q != WORDS);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_AUD;
      rd_q       <= 1'b0;
      lba_q      <= 32'd0;
      streak_q   <= '0;
      tmo_q      <= '0;
      wcnt_q     <= '0;
      aud_done_q <= 1'b0;
      aud_err_q  <= 1'b0;
      dat_done_q <= 1'b0;
      dat_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      lba_q      <= lba_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      wcnt_q     <= wcnt_d;
      aud_done_q <= aud_done_d;
      aud_err_q  <= aud_err_d;
      dat_done_q <= dat_done_d;
      dat_err_q  <= dat_err_d;
    end
  end

  logic xfer_wr;
  assign xfer_wr = (state_q == XFER) && sd_ack_i && sd_buff_wr_i;

  assign aud_buff_wr_o = xfer_wr && (owner_q == OWN_AUD);
  assign dat_buff_wr_o = xfer_wr && (owner_q == OWN_DAT);
  assign aud_busy_o    = aud_pend || ((owner_q == OWN_AUD) && (state_q != IDLE));
  assign dat_busy_o    = dat_pend || ((owner_q == OWN_DAT) && (state_q != IDLE));
  assign aud_done_o    = aud_done_q;
  assign aud_err_o     = aud_err_q;
  assign dat_done_o    = dat_done_q;
  assign dat_err_o     = dat_err_q;
  assign sd_rd_o       = rd_q;
  assign sd_lba_o      = lba_q;

endmodule

`default_nettype wire

// File: tb/tb_msu_sd_arbiter.sv
// ------------------------------------------------------------------
// tb_msu_sd_arbiter: directed self-checking bench for msu_sd_arbiter.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_msu_sd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        aud_req, dat_req, sd_ack, sd_buff_wr;
  logic [31:0] aud_lba, dat_lba;
  logic        aud_busy, aud_buff_wr, aud_done, aud_err;
  logic        dat_busy, dat_buff_wr, dat_done, dat_err;
  logic [31:0] sd_lba;
  logic        sd_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msu_sd_arbiter #(
    .SECTOR_WORDS   (256),
    .TIMEOUT        (16),
    .AUD_STREAK_MAX (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .aud_req_i     (aud_req),
    .aud_lba_i     (aud_lba),
    .aud_busy_o    (aud_busy),
    .aud_buff_wr_o (aud_buff_wr),
    .aud_done_o    (aud_done),
    .aud_err_o     (aud_err),
    .dat_req_i     (dat_req),
    .dat_lba_i     (dat_lba),
    .dat_busy_o    (dat_busy),
    .dat_buff_wr_o (dat_buff_wr),
    .dat_done_o    (dat_done),
    .dat_err_o     (dat_err),
    .sd_lba_o      (sd_lba),
    .sd_rd_o       (sd_rd),
    .sd_ack_i      (sd_ack),
    .sd_buff_wr_i  (sd_buff_wr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd;
    int n = 0;
    while (!sd_rd && n < 50) begin
      step;
      n++;
    end
    chk("rd_rise", sd_rd, 1'b1);
  endtask

  // Host model: ack after w cycles, n strobes, drop ack; ends in the done/err cycle.
  task automatic serve(input int w, input int nstrb, input bit inj, input logic [31:0] inj_lba,
                       output int na, output int nd);
    na = 0;
    nd = 0;
    repeat (w) step;
    sd_ack = 1'b1;
    step;
    chk("rd_drop_on_ack", sd_rd, 1'b0);
    for (int i = 0; i < nstrb; i++) begin
      sd_buff_wr = 1'b1;
      if (inj && i == 10) begin
        aud_req = 1'b1;
        aud_lba = inj_lba;
      end
      #1;
      if (aud_buff_wr) na++;
      if (dat_buff_wr) nd++;
      step;
      aud_req = 1'b0;
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    step;
  endtask

  logic [31:0] exp_lba [6];
  int na, nd, n, ai;

  initial begin
    rst = 1'b1; aud_req = 1'b0; dat_req = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    aud_lba = 32'd0; dat_lba = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sd_rd", sd_rd, 1'b0);
    chk("rst_sd_lba", sd_lba, 32'h0);
    chk("rst_busy", {aud_busy, dat_busy}, 2'b00);
    chk("rst_pulses", {aud_done, aud_err, dat_done, dat_err}, 4'b0000);
    rst = 1'b0;
    step;

    // Single audio sector
    aud_req = 1'b1; aud_lba = 32'h10;
    step;
    aud_req = 1'b0;
    chk("t1_busy_latched", aud_busy, 1'b1);
    chk("t1_rd_not_yet", sd_rd, 1'b0);
    step;
    chk("t1_rd", sd_rd, 1'b1);
    chk("t1_lba", sd_lba, 32'h10);
    serve(5, 256, 1'b0, 32'h0, na, nd);
    chk("t1_aud_wr_cnt", na, 256);
    chk("t1_dat_wr_cnt", nd, 0);
    chk("t1_done", {aud_done, aud_err}, 2'b10);
    chk("t1_busy_done", aud_busy, 1'b0);
    step;
    chk("t1_done_gone", aud_done, 1'b0);
    chk("t1_busy_after", aud_busy, 1'b0);

    // Overlap, ignored third request, short and long sectors
    aud_req = 1'b1; aud_lba = 32'h30;
    step;
    aud_req = 1'b0;
    wait_rd;
    chk("ov_lba0", sd_lba, 32'h30);
    serve(1, 256, 1'b1, 32'h31, na, nd);
    chk("ov_done", {aud_done, aud_err}, 2'b10);
    chk("ov_busy_pending", aud_busy, 1'b1);
    chk("ov_rd_low_done", sd_rd, 1'b0);
    aud_req = 1'b1; aud_lba = 32'h32;
    step;
    aud_req = 1'b0;
    chk("ov_rd_rerise", sd_rd, 1'b1);
    chk("ov_lba1", sd_lba, 32'h31);
    serve(1, 255, 1'b0, 32'h0, na, nd);
    chk("short_cnt", na, 255);
    chk("short_err", {aud_done, aud_err}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("ov_third_ignored", {sd_rd, aud_busy}, 2'b00);
    end
    aud_req = 1'b1; aud_lba = 32'h33;
    step;
    aud_req = 1'b0;
    wait_rd;
    chk("long_lba", sd_lba, 32'h33);
    serve(0, 257, 1'b0, 32'h0, na, nd);
    chk("long_cnt", na, 257);
    chk("long_err", {aud_done, aud_err}, 2'b01);

    // Timeout on a data request, audio queued behind it
    step;
    dat_req = 1'b1; dat_lba = 32'h40;
    step;
    dat_req = 1'b0;
    wait_rd;
    chk("to_lba", sd_lba, 32'h40);
    n = 0;
    while (sd_rd && n < 40) begin
      n++;
      if (n == 1) begin
        aud_req = 1'b1; aud_lba = 32'h14;
      end
      step;
      aud_req = 1'b0;
    end
    chk("to_rd_cycles", n, 16);
    chk("to_dat_pulses", {dat_done, dat_err}, 2'b01);
    chk("to_aud_pending", aud_busy, 1'b1);
    step;
    chk("to_next_rd", sd_rd, 1'b1);
    chk("to_next_lba", sd_lba, 32'h14);
    chk("to_dat_idle", {dat_busy, dat_err}, 2'b00);
    serve(2, 256, 1'b0, 32'h0, na, nd);
    chk("to_aud_done", {aud_done, aud_err}, 2'b10);

    // Async reset in the middle of a transfer
    step;
    aud_req = 1'b1; aud_lba = 32'h50;
    step;
    aud_req = 1'b0;
    wait_rd;
    sd_ack = 1'b1;
    step;
    sd_buff_wr = 1'b1;
    dat_req = 1'b1; dat_lba = 32'h60;
    step;
    dat_req = 1'b0;
    chk("ar_pre_wr", aud_buff_wr, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_rd", sd_rd, 1'b0);
    chk("ar_busy", {aud_busy, dat_busy}, 2'b00);
    chk("ar_wr", {aud_buff_wr, dat_buff_wr}, 2'b00);
    step;
    step;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("ar_spurious_wr", {aud_buff_wr, dat_buff_wr, sd_rd}, 3'b000);
      chk("ar_no_pulse", {aud_done, aud_err, dat_done, dat_err}, 4'b0000);
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    step;

    // Starvation guard: A,A,A,A,D,A
    exp_lba = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hD0, 32'hA4};
    aud_req = 1'b1; aud_lba = 32'hA0;
    dat_req = 1'b1; dat_lba = 32'hD0;
    step;
    aud_req = 1'b0; dat_req = 1'b0;
    ai = 1;
    for (int g = 0; g < 6; g++) begin
      wait_rd;
      chk("sv_grant_lba", sd_lba, exp_lba[g]);
      if (g == 4) begin
        serve(0, 256, 1'b0, 32'h0, na, nd);
        chk("sv_dat_wr", nd, 256);
        chk("sv_dat_done", {dat_done, aud_done}, 2'b10);
      end else begin
        serve(0, 256, 1'b1, 32'hA0 + 32'(ai), na, nd);
        ai++;
        chk("sv_aud_wr", na, 256);
        chk("sv_aud_done", {aud_done, dat_done}, 2'b10);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
